// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the hardwired control sequencer.
// Contents: state encoding, opcode width, opcode constants, instruction-class helper.
// Latency/backpressure: n/a (package only).
package cpu_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // Execute-phase shape of an instruction.
  //   CLS_A : two-operand, Y <- Rb, Z <- Y op Rc, Ra <- Zlo
  //   CLS_U : one-operand, Z <- op Rb, Ra <- Zlo
  //   CLS_M : Y <- Ra, Z <- Y op Rb, LO <- Zlo, HI <- Zhi
  typedef enum logic [2:0] {
    CLS_A    = 3'd0,
    CLS_U    = 3'd1,
    CLS_M    = 3'd2,
    CLS_NOP  = 3'd3,
    CLS_HALT = 3'd4,
    CLS_ILL  = 3'd5
  } op_class_t;

  function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
    op_class_t cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: cls = CLS_A;
      OPC_NEG, OPC_NOT:                   cls = CLS_U;
      OPC_MUL, OPC_DIV:                   cls = CLS_M;
      OPC_NOP:                            cls = CLS_NOP;
      OPC_HALT:                           cls = CLS_HALT;
      default:                            cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Purpose: 4-bit register field to one-hot select; all zero when i_valid is low.
// Latency: combinational. Backpressure: none.
// Ports: i_field (register index), i_valid (qualify), o_onehot (NUM_REGS-bit select).
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          i_field,
  input  logic                i_valid,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_onehot[i] = i_valid && (i_field == 4'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: hardwired fetch/decode/execute sequencer driving single-bus datapath strobes.
// Latency: one T-state per clock; fetch 3+ cycles, execute 1..4 cycles by instruction class.
// Backpressure: T1 holds read/mdr_enable until mem_ready; HALT holds until resume.
// Ports: clk/clr (sync active-high reset), ir + mem_ready + resume in;
//        bus-driver selects, register load strobes, read, op_code, halted, illegal_op out.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                pc_out,
  output logic                mdr_out,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                mar_enable,
  output logic                mdr_enable,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic                pc_increment,
  output logic                read,
  output logic [OPC_W-1:0]    op_code,
  output logic                halted,
  output logic                illegal_op
);

  state_t           r_state;
  state_t           w_next_state;

  logic [OPC_W-1:0] r_opc;
  logic [3:0]       r_ra;
  logic [3:0]       r_rb;
  logic [3:0]       r_rc;

  logic [OPC_W-1:0] w_opc;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic [3:0]       w_rc;
  op_class_t        w_class;

  logic [3:0]       w_out_field;
  logic             w_out_vld;
  logic [3:0]       w_en_field;
  logic             w_en_vld;

  logic             w_ir_unused;
  assign w_ir_unused = ^ir[14:0];

  // IR is loaded on the edge that leaves T2, so during T3 the fields are read
  // straight from ir and captured at the end of T3; T4..T6 use the captured copy.
  assign w_opc   = (r_state == S_T3) ? ir[31:27] : r_opc;
  assign w_ra    = (r_state == S_T3) ? ir[26:23] : r_ra;
  assign w_rb    = (r_state == S_T3) ? ir[22:19] : r_rb;
  assign w_rc    = (r_state == S_T3) ? ir[18:15] : r_rc;
  assign w_class = op_class(w_opc);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RST;
      r_opc   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_T3) begin
        r_opc <= ir[31:27];
        r_ra  <= ir[26:23];
        r_rb  <= ir[22:19];
        r_rc  <= ir[18:15];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    pc_out       = 1'b0;
    mdr_out      = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    mar_enable   = 1'b0;
    mdr_enable   = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    pc_increment = 1'b0;
    read         = 1'b0;
    op_code      = '0;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    w_out_field  = 4'd0;
    w_out_vld    = 1'b0;
    w_en_field   = 4'd0;
    w_en_vld     = 1'b0;

    case (r_state)
      S_RST: w_next_state = S_T0;

      S_T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        w_next_state = S_T1;
      end

      S_T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
        if (mem_ready) w_next_state = S_T2;
      end

      S_T2: begin
        mdr_out      = 1'b1;
        ir_enable    = 1'b1;
        w_next_state = S_T3;
      end

      S_T3: begin
        case (w_class)
          CLS_A: begin
            w_out_field  = w_rb;
            w_out_vld    = 1'b1;
            y_enable     = 1'b1;
            w_next_state = S_T4;
          end
          CLS_U: begin
            w_out_field  = w_rb;
            w_out_vld    = 1'b1;
            op_code      = w_opc;
            z_enable     = 1'b1;
            w_next_state = S_T4;
          end
          CLS_M: begin
            w_out_field  = w_ra;
            w_out_vld    = 1'b1;
            y_enable     = 1'b1;
            w_next_state = S_T4;
          end
          CLS_HALT: w_next_state = S_HALT;
          CLS_ILL: begin
            illegal_op   = 1'b1;
            w_next_state = S_T0;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T4: begin
        case (w_class)
          CLS_A: begin
            w_out_field  = w_rc;
            w_out_vld    = 1'b1;
            op_code      = w_opc;
            z_enable     = 1'b1;
            w_next_state = S_T5;
          end
          CLS_U: begin
            zlo_out      = 1'b1;
            w_en_field   = w_ra;
            w_en_vld     = 1'b1;
            w_next_state = S_T0;
          end
          CLS_M: begin
            w_out_field  = w_rb;
            w_out_vld    = 1'b1;
            op_code      = w_opc;
            z_enable     = 1'b1;
            w_next_state = S_T5;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T5: begin
        case (w_class)
          CLS_A: begin
            zlo_out      = 1'b1;
            w_en_field   = w_ra;
            w_en_vld     = 1'b1;
            w_next_state = S_T0;
          end
          CLS_M: begin
            zlo_out      = 1'b1;
            lo_enable    = 1'b1;
            w_next_state = S_T6;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T6: begin
        zhi_out      = 1'b1;
        hi_enable    = 1'b1;
        w_next_state = S_T0;
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) w_next_state = S_T0;
      end

      default: w_next_state = S_RST;
    endcase

    if (clr) w_next_state = S_RST;
  end

  // Source and destination selects are never active in the same state, so a
  // register cannot drive and load the bus in one cycle.
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .i_field  (w_out_field),
    .i_valid  (w_out_vld),
    .o_onehot (reg_out)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_en_dec (
    .i_field  (w_en_field),
    .i_valid  (w_en_vld),
    .o_onehot (reg_enable)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: directed bench for control_sequencer with a behavioural single-bus datapath.
// Latency: every cycle's expected strobe word is queued by stimulus and popped by the monitor.
// Backpressure: mem_ready stalls and HALT/resume are driven from the stimulus tables.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] ir;

  logic        pc_out, mdr_out, zlo_out, zhi_out;
  logic [15:0] reg_out, reg_enable;
  logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
  logic        lo_enable, hi_enable, pc_increment, read, halted, illegal_op;
  logic [4:0]  op_code;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_REGS(16)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .resume(resume),
    .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .reg_out(reg_out), .reg_enable(reg_enable),
    .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
    .y_enable(y_enable), .z_enable(z_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
    .pc_increment(pc_increment), .read(read), .op_code(op_code),
    .halted(halted), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic        pc_out, mdr_out, zlo_out, zhi_out;
    logic [15:0] reg_out, reg_en;
    logic        mar_en, mdr_en, ir_en, y_en, z_en, lo_en, hi_en, pc_inc, read;
    logic [4:0]  op;
    logic        halted, ill;
  } ctl_t;

  typedef struct {
    int          what;   // 0..15 = Rn, 16 = LO, 17 = HI
    logic [31:0] val;
  } chk_t;

  ctl_t sb[$];
  chk_t pend[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  // ---------------- behavioural datapath ----------------
  logic [31:0] m_pc = 0, m_mar = 0, m_mdr = 0, m_ir = 0, m_y = 0, m_lo = 0, m_hi = 0;
  logic [63:0] m_z = 0;
  logic [31:0] m_r[16];
  logic [31:0] mem[16];
  logic [15:0] pl_mask = 16'h0;
  logic [31:0] pl_val[16];
  logic [31:0] m_bus;

  assign ir = m_ir;

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
    logic [63:0] yy;
    yy = {y, y};
    case (op)
      5'b00011: return {32'h0, y + b};
      5'b00100: return {32'h0, y - b};
      5'b00101: return {32'h0, y & b};
      5'b00110: return {32'h0, y | b};
      5'b00111: return {32'h0, y >> b[4:0]};
      5'b01000: return {32'h0, y << b[4:0]};
      5'b01001: return {32'h0, 32'(yy >> b[4:0])};
      5'b01010: return {32'h0, 32'((yy << b[4:0]) >> 32)};
      5'b01111: return {32'h0, y} * {32'h0, b};
      5'b10000: return (b == 0) ? 64'h0 : {y % b, y / b};
      5'b10001: return {32'h0, -b};
      5'b10010: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  always_comb begin
    m_bus = 32'h0;
    for (int i = 0; i < 16; i++) if (reg_out[i]) m_bus = m_r[i];
    if (zhi_out) m_bus = m_z[63:32];
    if (zlo_out) m_bus = m_z[31:0];
    if (mdr_out) m_bus = m_mdr;
    if (pc_out)  m_bus = m_pc;
  end

  always @(posedge clk) begin
    if (pc_increment) m_pc <= m_pc + 1;
    if (mar_enable)   m_mar <= m_bus;
    if (mdr_enable)   m_mdr <= read ? (mem_ready ? mem[m_mar[3:0]] : 32'hBAD0BAD0) : m_bus;
    if (ir_enable)    m_ir <= m_bus;
    if (y_enable)     m_y <= m_bus;
    if (z_enable)     m_z <= alu(op_code, m_y, m_bus);
    if (lo_enable)    m_lo <= m_bus;
    if (hi_enable)    m_hi <= m_bus;
    for (int i = 0; i < 16; i++) begin
      if (reg_enable[i])   m_r[i] <= m_bus;
      else if (pl_mask[i]) m_r[i] <= pl_val[i];
    end
  end

  // ---------------- monitor ----------------
  ctl_t mon_got, mon_exp;
  always @(negedge clk) begin
    cyc_no++;
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_got = {pc_out, mdr_out, zlo_out, zhi_out, reg_out, reg_enable,
                 mar_enable, mdr_enable, ir_enable, y_enable, z_enable, lo_enable,
                 hi_enable, pc_increment, read, op_code, halted, illegal_op};
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL ctl cycle %0d: got %h expected %h", cyc_no, mon_got, mon_exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc(input logic [4:0] opc, input logic [3:0] ra, rb, rc);
    return {opc, ra, rb, rc, 15'h0};
  endfunction

  function automatic ctl_t x_exec(input logic [15:0] ro, re, input logic [4:0] op,
                                  input logic y, z, zlo, zhi, lo, hi, ill);
    ctl_t e;
    e = '0;
    e.reg_out = ro; e.reg_en = re; e.op = op;
    e.y_en = y; e.z_en = z; e.zlo_out = zlo; e.zhi_out = zhi;
    e.lo_en = lo; e.hi_en = hi; e.ill = ill;
    return e;
  endfunction

  // Inputs for the cycle that just started; expected outputs for that same cycle.
  // Pending result checks refer to datapath state written by the edge just passed.
  task automatic cyc(input ctl_t e, input logic mr, input logic rs, input logic cl,
                     input logic [15:0] plm);
    chk_t c;
    logic [31:0] act;
    @(posedge clk);
    #1;
    while (pend.size() > 0) begin
      c = pend.pop_front();
      act = (c.what < 16) ? m_r[c.what] : ((c.what == 16) ? m_lo : m_hi);
      n_checks++;
      if (act !== c.val) begin
        n_fail++;
        $display("FAIL result[%0d]: got %h expected %h", c.what, act, c.val);
      end
    end
    mem_ready = mr; resume = rs; clr = cl; pl_mask = plm;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [15:0] plm, input int stalls);
    ctl_t e;
    e = '0; e.pc_out = 1; e.mar_en = 1; e.pc_inc = 1;
    cyc(e, 0, 0, 0, plm);
    e = '0; e.read = 1; e.mdr_en = 1;
    for (int i = 0; i < stalls; i++) cyc(e, 0, 0, 0, 16'h0);
    cyc(e, 1, 0, 0, 16'h0);
    e = '0; e.mdr_out = 1; e.ir_en = 1;
    cyc(e, 0, 0, 0, 16'h0);
  endtask

  task automatic push_chk(input int what, input logic [31:0] val);
    chk_t c;
    c.what = what; c.val = val;
    pend.push_back(c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ctl_t e;
    mem[0] = 32'h8A800000;                  // NEG R5, R0
    mem[1] = enc(5'b00011, 4'd1, 4'd2, 4'd3); // ADD R1, R2, R3
    mem[2] = enc(5'b01111, 4'd3, 4'd4, 4'd0); // MUL R3, R4
    mem[3] = enc(5'b11011, 4'd0, 4'd0, 4'd0); // HALT
    mem[4] = enc(5'b11111, 4'd1, 4'd2, 4'd3); // illegal
    mem[5] = enc(5'b00011, 4'd1, 4'd2, 4'd3); // ADD, cut short by clr
    mem[6] = enc(5'b11010, 4'd0, 4'd0, 4'd0); // NOP
    for (int i = 7; i < 16; i++) mem[i] = enc(5'b11010, 4'd0, 4'd0, 4'd0);

    // reset: two cycles of RST with everything low
    cyc('0, 0, 0, 1, 16'h0);
    cyc('0, 0, 0, 0, 16'h0);

    // NEG: R0 = 0x24 -> R5 = 0xFFFFFFDC
    pl_val[0] = 32'h00000024;
    fetch(16'h0001, 0);
    cyc(x_exec(16'h0001, 16'h0000, 5'b10001, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0000, 16'h0020, 5'b00000, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    push_chk(5, 32'hFFFFFFDC);

    // ADD: R2 = 5, R3 = 7 -> R1 = 12
    pl_val[1] = 32'h0; pl_val[2] = 32'd5; pl_val[3] = 32'd7;
    fetch(16'h000E, 0);
    cyc(x_exec(16'h0004, 16'h0000, 5'b00000, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0008, 16'h0000, 5'b00011, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0000, 16'h0002, 5'b00000, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    push_chk(1, 32'd12);

    // MUL with a 3-cycle memory stall: R3 = 6, R4 = 7 -> LO = 42, HI = 0
    pl_val[3] = 32'd6; pl_val[4] = 32'd7;
    fetch(16'h0018, 3);
    cyc(x_exec(16'h0008, 16'h0000, 5'b00000, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0010, 16'h0000, 5'b01111, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0000, 16'h0000, 5'b00000, 0, 0, 1, 0, 1, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1, 0, 1, 0), 0, 0, 0, 16'h0);
    push_chk(16, 32'd42);
    push_chk(17, 32'd0);

    // HALT: T3 quiet, then halted for 10 cycles, resume pulse, T0 next
    fetch(16'h0, 0);
    cyc('0, 0, 0, 0, 16'h0);
    e = '0; e.halted = 1;
    for (int i = 0; i < 10; i++) cyc(e, 0, 0, 0, 16'h0);
    cyc(e, 0, 1, 0, 16'h0);

    // illegal opcode: one-cycle illegal_op in T3, nothing else, then T0
    fetch(16'h0, 0);
    cyc(x_exec(16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 16'h0);

    // ADD interrupted by clr during T4: RST next, R1 keeps 0, then T0
    pl_val[1] = 32'h0; pl_val[2] = 32'd5; pl_val[3] = 32'd7;
    fetch(16'h000E, 0);
    cyc(x_exec(16'h0004, 16'h0000, 5'b00000, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 16'h0);
    cyc(x_exec(16'h0008, 16'h0000, 5'b00011, 0, 1, 0, 0, 0, 0, 0), 0, 0, 1, 16'h0);
    cyc('0, 0, 0, 0, 16'h0);
    push_chk(1, 32'h0);

    // NOP: T3 quiet, then the next fetch starts
    fetch(16'h0, 0);
    cyc('0, 0, 0, 0, 16'h0);
    e = '0; e.pc_out = 1; e.mar_en = 1; e.pc_inc = 1;
    cyc(e, 0, 0, 0, 16'h0);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0 || pend.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", sb.size(), pend.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that sequences the shared single-bus Datapath through fetch, decode and execute phases for register-register ALU instructions. It replaces hand-driven strobes with a state machine that asserts bus-driver selects, register enables, memory read and the ALU op_code, one T-state per clock.
Stalls T1 on a memory-ready handshake. Decodes IR fields into one-hot register selects and handles HALT and unsupported opcodes.

Parameters:
NUM_REGS, 16, general-purpose register count; width of the one-hot select buses
OPC_W, 5, opcode field width (IR[31:27])

Ports:
clk  in  1  system clock; all state changes on the rising edge
clr  in  1  synchronous active-high reset
ir  in  32  current IR contents from Datapath
mem_ready  in  1  memory has valid data on m_data_in this cycle
resume  in  1  leave HALT and begin the next fetch
pc_out  out  1  PC drives bus
mdr_out  out  1  MDR drives bus
zlo_out  out  1  Z[31:0] drives bus
zhi_out  out  1  Z[63:32] drives bus
reg_out  out  NUM_REGS  one-hot: Rn drives bus
reg_enable  out  NUM_REGS  one-hot: Rn loads from bus
mar_enable, mdr_enable, ir_enable, y_enable, z_enable, lo_enable, hi_enable  out  1 each  register load strobes
pc_increment  out  1  PC <= PC+1
read  out  1  MDR input mux selects memory
op_code  out  OPC_W  ALU operation
halted  out  1  sequencer is in HALT
illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- IR fields: opcode=IR[31:27], ra=IR[26:23] (destination), rb=IR[22:19], rc=IR[18:15].
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. State is registered. Outputs are a combinational decode of state plus latched opcode/fields.
- clr high: next state RST regardless of current state, including mid-instruction and during T1 stall. In RST all outputs are 0 and op_code=0. RST goes to T0 on the next cycle when clr is low.
- T0: pc_out, mar_enable, pc_increment. Go to T1.
- T1: read=1, mdr_enable=1 while waiting. Stay in T1 until mem_ready=1; leave T1 on the cycle mem_ready is sampled high. There is no stall limit.
- T2: mdr_out, ir_enable. Go to T3. At the end of T2, latch opcode, ra, rb and rc from the bus value. IR loads on the same edge, so latch from ir on the T3 entry cycle: capture ir at the end of T3's first cycle via a combinational read in T3. Fields are held until the next T2.
- Class A (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL):
  - T3: reg_out[rb], y_enable.
  - T4: reg_out[rc], op_code=opc, z_enable.
  - T5: zlo_out, reg_enable[ra].
  - Then T0.
- Class U (NEG, NOT):
  - T3: reg_out[rb], op_code=opc, z_enable.
  - T4: zlo_out, reg_enable[ra].
  - Then T0.
- Class M (MUL, DIV):
  - T3: reg_out[ra], y_enable.
  - T4: reg_out[rb], op_code=opc, z_enable.
  - T5: zlo_out, lo_enable.
  - T6: zhi_out, hi_enable.
  - Then T0.
- NOP: T3 asserts nothing, then T0.
- HALT: T3 goes to HALT. The halted output stays 1 and all strobes stay 0. resume=1 goes to T0.
- Any other opcode: behave as NOP and pulse illegal_op for exactly the T3 cycle.
- Invariant: at most one bus driver (pc_out, mdr_out, zlo_out, zhi_out, any reg_out bit) is high in any cycle. op_code is 0 outside its execute cycle.
- Field index 0 maps to R0. reg_out and reg_enable are never both set for the same register.

Decomposition:
- Package cpu_pkg holds the state enum and OPC_W.
- It also holds the opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
- One sub-module, reg_select_decoder: 4-bit field plus valid in, NUM_REGS-bit one-hot out. It is instantiated for the out and enable paths.

Test Plan:
- NEG: R0=0x00000024, IR=0x8A800000, mem_ready high in T1 -> T3 asserts reg_out[0], op_code=10001, z_enable; T4 asserts zlo_out, reg_enable[5]; R5=0xFFFFFFDC; next fetch after 5 cycles from T0.
- ADD: R2=5, R3=7, ra=1 -> y_enable with reg_out[2] in T3, reg_out[3] with op_code=00011 in T4; R1=12 after T5; total 6 cycles.
- MUL stall: mem_ready held low 3 cycles in T1 -> read/mdr_enable held 4 cycles. R3=6, R4=7 -> LO=42, HI=0 after T6.
- HALT then resume: opcode 11011 -> halted=1, all strobes 0 for 10 cycles. resume pulse -> T0 next cycle.
- Illegal opcode 11111 -> illegal_op high for exactly one cycle in T3, no register enable, then T0.
- clr asserted during T4 of ADD -> next cycle RST with all outputs 0, R1 not written, T0 on the second cycle after clr drops.
